pwm_multi_ch: RTL and testbench
===============================

Name: pwm_multi_ch

Overview:
Parametrised N-channel PWM generator and successor to the 3-output single-counter PWM. It uses one shared prescaler and one shared duty counter. Each channel has its own duty register, double-buffered so that updates land only on period boundaries. Two modes: plain PWM (fast divisor) and servo mode (slow divisor, duty remapped to a 1-2 ms pulse window). It sits behind the TinyTapeout top-level pin mux and drives the PWM pins directly.

Parameters:
CHANNELS, 3, number of independent PWM outputs (1-8)
CNT_W, 8, duty counter and duty register width; period = 2^CNT_W ticks
PRE_W, 18, prescaler counter width; must hold max(DIV_PWM, DIV_SERVO)
DIV_PWM, 10416, prescaler divisor in plain mode (clk cycles per tick)
DIV_SERVO, 200000, prescaler divisor in servo mode
SERVO_BASE, 13, servo threshold offset in ticks (about 1 ms at 50 Hz, 256 steps)
SERVO_SPAN, 13, servo threshold span in ticks added at full-scale duty

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-high (port name retained from top level)
ena  input  1  run enable; low freezes counters and forces outputs low
mode  input  1  0 = plain PWM, 1 = servo; sampled only at period boundary
duty_we  input  1  write strobe for one channel's shadow duty register
duty_ch  input  $clog2(CHANNELS) (min 1)  channel index for the write
duty_in  input  CNT_W  duty value to write
pwm_out  output  CHANNELS  registered PWM outputs
period_tick  output  1  one-cycle pulse on each period boundary
mode_act  output  1  mode currently in effect

Behaviour:
- Reset (rst_n=1 at posedge clk): prescaler, duty counter, all shadow and active duty registers = 0; mode_act=0; pwm_out=0; period_tick=0. Reset overrides ena and duty_we.
- Prescaler q (PRE_W bits): when ena=1, counts 0..DIV-1, where DIV is selected by mode_act. On the clock where q==DIV-1, q wraps to 0 and the internal tick pulses for one cycle.
- Duty counter d (CNT_W bits): increments on tick and wraps from 2^CNT_W-1 to 0. The wrap event is tick && d==max.
- At wrap (same clock edge): active[i] <= shadow[i] for all channels; mode_act <= mode; period_tick <= 1 for exactly one cycle.
- Shadow write: when duty_we=1 and duty_ch<CHANNELS, shadow[duty_ch] <= duty_in. duty_ch>=CHANNELS is ignored. Multiple writes within one period: the last one wins.
- Write on the wrap cycle: active takes the old shadow value; the new value applies at the following wrap.
- Threshold: plain thr_i = active[i]. Servo thr_i = SERVO_BASE + ((active[i]*SERVO_SPAN) >> CNT_W). Compute at CNT_W+$clog2(SERVO_SPAN)+1 bits, no truncation before the compare.
- Output: pwm_out[i] <= (d < thr_i), registered, so it lags the counter by 1 clk. Duty 0 in plain mode gives a constant 0. Duty 255 (CNT_W=8) gives 255/256 high; the output is never constant 1 in plain mode.
- ena=0: q and d hold; pwm_out <= 0 next clock; shadow writes still accepted; no wrap, so no transfer and no period_tick. ena re-asserted: counting resumes from the held q and d.
- mode change mid-period: no effect until the next wrap, so there is no truncated period. DIV switches at the wrap, and q restarts from 0 on the new DIV.
- Reset mid-period: all state is cleared on the same edge; the next period starts at q=0, d=0.

Optional Feature:
PWM_CENTER_ALIGNED_EN: when defined, d counts up 0..max, then down max..0 (triangle), so the period is 2*(2^CNT_W-1) ticks.
- Boundary (shadow transfer, mode latch, period_tick) occurs at the bottom only: tick while counting down with d==1, moving to 0.
- pwm_out[i] is symmetric about the top; high time = 2*thr_i-1 ticks for thr_i>0.
- An added direction flop resets to up.
- When undefined: edge-aligned sawtooth as above; no direction flop.

Test Plan:
- Reset/idle (CHANNELS=3, CNT_W=4, DIV_PWM=4): rst_n=1 for 3 clk, then ena=1 with all duty=0 -> pwm_out=3'b000 for 2 full periods; period_tick every 64 clk.
- Shadow timing: write ch1=8 mid-period -> pwm_out[1] stays 0 until the first wrap, then high for 8 ticks (32 clk) of each 16-tick period; ch0 and ch2 stay 0.
- Edge duties: ch0=15, ch2=1 -> ch0 high for 60 of 64 clk, ch2 high for 4 of 64 clk; ch_sel=3 write -> no change on any output.
- Wrap-cycle write: write ch0=5 on the same clk as the wrap, with the prior shadow=2 -> the next period shows 2 ticks high, the following period shows 5.
- Servo mode (CNT_W=8, DIV_SERVO=8, SERVO_BASE=13, SERVO_SPAN=13): mode=1, duty=255 -> mode_act=1 after the wrap; high for 25 ticks; duty=0 -> 13 ticks.
- ena gating/reset mid-run: ena=0 for 10 clk -> pwm_out=0, counters frozen, period length extended by 10 clk. Assert rst_n mid-period -> all outputs 0 next clk, shadows cleared.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// N-channel PWM generator with a shared prescaler, shared duty counter and double-buffered duty registers.
// Optional macro PWM_CENTER_ALIGNED_EN switches the counter from sawtooth to up/down triangle.
module pwm_multi_ch #(
  parameter int CHANNELS   = 3,
  parameter int CNT_W      = 8,
  parameter int PRE_W      = 18,
  parameter int DIV_PWM    = 10416,
  parameter int DIV_SERVO  = 200000,
  parameter int SERVO_BASE = 13,
  parameter int SERVO_SPAN = 13
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               ena,
  input  logic                                               mode,
  input  logic                                               duty_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] duty_ch,
  input  logic [CNT_W-1:0]                                   duty_in,
  output logic [CHANNELS-1:0]                                pwm_out,
  output logic                                               period_tick,
  output logic                                               mode_act
);

  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int THR_W  = CNT_W + $clog2(SERVO_SPAN) + 1;
  localparam int PROD_W = CNT_W + THR_W;

  localparam logic [PRE_W-1:0]  PRE_LAST_PWM   = PRE_W'(DIV_PWM - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST_SERVO = PRE_W'(DIV_SERVO - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX        = {CNT_W{1'b1}};
  localparam logic [THR_W-1:0]  BASE_T         = THR_W'(SERVO_BASE);
  localparam logic [PROD_W-1:0] SPAN_P         = PROD_W'(SERVO_SPAN);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    shadow_q [CHANNELS];
  logic [CNT_W-1:0]    shadow_d [CHANNELS];
  logic [CNT_W-1:0]    active_q [CHANNELS];
  logic [CNT_W-1:0]    active_d [CHANNELS];
  logic                mode_act_q, mode_act_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_tick_q, period_tick_d;
  logic [THR_W-1:0]    thr [CHANNELS];
  logic [PROD_W-1:0]   prod;
  logic                tick;
  logic                wrap;

`ifdef PWM_CENTER_ALIGNED_EN
  logic dir_up_q, dir_up_d;
`endif

  // Tick on the last prescaler count of whichever divisor is in effect.
  always_comb begin
    tick  = ena && (pre_q == (mode_act_q ? PRE_LAST_SERVO : PRE_LAST_PWM));
    pre_d = pre_q;
    if (ena) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end
  end

`ifdef PWM_CENTER_ALIGNED_EN
  // Triangle counter: the period boundary is the step from 1 down to 0.
  always_comb begin
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    wrap     = tick && !dir_up_q && (cnt_q == CNT_W'(1));
    if (tick) begin
      if (dir_up_q) begin
        if (cnt_q == CNT_MAX) begin
          cnt_d    = cnt_q - CNT_W'(1);
          dir_up_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          dir_up_d = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    cnt_d = cnt_q;
    wrap  = tick && (cnt_q == CNT_MAX);
    if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
`endif

  // The transfer reads the pre-write shadow, so a write on the wrap cycle waits a period.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      if (duty_we && (duty_ch == CH_W'(i))) begin
        shadow_d[i] = duty_in;
      end
      if (wrap) begin
        active_d[i] = shadow_q[i];
      end
    end
    mode_act_d    = wrap ? mode : mode_act_q;
    period_tick_d = wrap;
  end

  always_comb begin
    prod  = '0;
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      prod = PROD_W'(active_q[i]) * SPAN_P;
      if (mode_act_q) begin
        thr[i] = BASE_T + THR_W'(prod >> CNT_W);
      end else begin
        thr[i] = THR_W'(active_q[i]);
      end
      pwm_d[i] = ena && (THR_W'(cnt_q) < thr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pre_q         <= '0;
      cnt_q         <= '0;
      mode_act_q    <= 1'b0;
      pwm_q         <= '0;
      period_tick_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      pre_q         <= pre_d;
      cnt_q         <= cnt_d;
      mode_act_q    <= mode_act_d;
      pwm_q         <= pwm_d;
      period_tick_q <= period_tick_d;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

`ifdef PWM_CENTER_ALIGNED_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      dir_up_q <= 1'b1;
    end else begin
      dir_up_q <= dir_up_d;
    end
  end
`endif

  assign pwm_out     = pwm_q;
  assign period_tick = period_tick_q;
  assign mode_act    = mode_act_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: directed scenarios plus random traffic, checked every cycle against a
// phase-based reference model of the period/shadow/threshold rules.
module tb_pwm_multi_ch;

   localparam int CHANNELS   = 3;
   localparam int CNT_W      = 4;
   localparam int PRE_W      = 4;
   localparam int DIV_PWM    = 4;
   localparam int DIV_SERVO  = 6;
   localparam int SERVO_BASE = 3;
   localparam int SERVO_SPAN = 5;
   localparam int STEPS      = 1 << CNT_W;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       mode;
   logic       duty_we;
   logic [1:0] duty_ch;
   logic [3:0] duty_in;
   logic [2:0] pwm_out;
   logic       period_tick;
   logic       mode_act;

   int checks;
   int errors;

   // Reference model: position within the period in clocks, plus shadow/active duties.
   int       mPhase;
   int       mShadow [CHANNELS];
   int       mActive [CHANNELS];
   int       mMode;
   logic [2:0] mPwm;
   int       mTick;
   logic     curMode;

   pwm_multi_ch #(
      .CHANNELS(CHANNELS), .CNT_W(CNT_W), .PRE_W(PRE_W), .DIV_PWM(DIV_PWM),
      .DIV_SERVO(DIV_SERVO), .SERVO_BASE(SERVO_BASE), .SERVO_SPAN(SERVO_SPAN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .duty_we(duty_we),
      .duty_ch(duty_ch), .duty_in(duty_in), .pwm_out(pwm_out),
      .period_tick(period_tick), .mode_act(mode_act)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int periodClocks();
      return (mMode != 0 ? DIV_SERVO : DIV_PWM) * STEPS;
   endfunction

   // Advance the model by one clock using the rules: output from the tick index of the
   // current clock, boundary at the last clock of the period, transfer before any write.
   function automatic void modelStep(input logic r, input logic e, input logic md,
                                     input logic we, input int ch, input int din);
      int div;
      int tickIdx;
      int thr;
      logic [2:0] nextPwm;
      if (r) begin
         mPhase = 0;
         mMode  = 0;
         mPwm   = '0;
         mTick  = 0;
         for (int i = 0; i < CHANNELS; i++) begin
            mShadow[i] = 0;
            mActive[i] = 0;
         end
      end else begin
         div     = (mMode != 0) ? DIV_SERVO : DIV_PWM;
         tickIdx = mPhase / div;
         nextPwm = '0;
         for (int i = 0; i < CHANNELS; i++) begin
            thr = (mMode != 0) ? SERVO_BASE + (mActive[i] * SERVO_SPAN) / STEPS : mActive[i];
            if (e && tickIdx < thr) nextPwm[i] = 1'b1;
         end
         mTick = (e && mPhase == div * STEPS - 1) ? 1 : 0;
         if (mTick != 0) begin
            for (int i = 0; i < CHANNELS; i++) mActive[i] = mShadow[i];
            mMode  = md ? 1 : 0;
            mPhase = 0;
         end else if (e) begin
            mPhase++;
         end
         if (we && ch < CHANNELS) mShadow[ch] = din;
         mPwm = nextPwm;
      end
   endfunction

   // One clock: drive inputs, step the model on the edge, compare shortly after.
   task automatic applyStimulus(input logic r, input logic e, input logic md,
                                input logic we, input int ch, input int din);
      rst_n   = r;
      ena     = e;
      mode    = md;
      duty_we = we;
      duty_ch = 2'(ch);
      duty_in = 4'(din);
      @(posedge clk);
      modelStep(r, e, md, we, ch, din);
      #1;
      checkOutput("pwm_out", int'(pwm_out), int'(mPwm));
      checkOutput("period_tick", int'(period_tick), mTick);
      checkOutput("mode_act", int'(mode_act), mMode);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, curMode, 1'b0, 0, 0);
   endtask

   task automatic writeDuty(input int ch, input int v);
      applyStimulus(1'b0, 1'b1, curMode, 1'b1, ch, v);
   endtask

   task automatic waitWrap(input int budget);
      int n;
      n = 0;
      do begin
         idle(1);
         n++;
      end while (!period_tick && n < budget);
      if (!period_tick) checkOutput("wrap_timeout", 0, 1);
   endtask

   task automatic countHigh(input int n, output int c0, output int c1, output int c2);
      c0 = 0;
      c1 = 0;
      c2 = 0;
      for (int k = 0; k < n; k++) begin
         idle(1);
         c0 += int'(pwm_out[0]);
         c1 += int'(pwm_out[1]);
         c2 += int'(pwm_out[2]);
      end
   endtask

   initial begin
      int c0, c1, c2;
      int n;
      int ticks;
      logic r, e, we;
      checks  = 0;
      errors  = 0;
      curMode = 1'b0;
      rst_n   = 1'b1;
      ena     = 1'b0;
      mode    = 1'b0;
      duty_we = 1'b0;
      duty_ch = '0;
      duty_in = '0;

      // Reset for three clocks, ena and a write held active to show reset wins.
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 0, 9);
      checkOutput("reset_pwm", int'(pwm_out), 0);
      checkOutput("reset_tick", int'(period_tick), 0);
      checkOutput("reset_mode", int'(mode_act), 0);

      // Idle with zero duty: two periods, no output, a tick every 64 clocks.
      ticks = 0;
      n = 0;
      for (int k = 0; k < 2 * DIV_PWM * STEPS; k++) begin
         idle(1);
         ticks += int'(period_tick);
         n += int'(pwm_out != 3'b000);
      end
      checkOutput("idle_ticks", ticks, 2);
      checkOutput("idle_high", n, 0);

      // Mid-period writes, including an out-of-range channel.
      idle(10);
      writeDuty(1, 8);
      writeDuty(0, 15);
      writeDuty(2, 1);
      writeDuty(3, 9);
      waitWrap(200);
      countHigh(DIV_PWM * STEPS, c0, c1, c2);
      checkOutput("edge_ch0_high", c0, 60);
      checkOutput("edge_ch1_high", c1, 32);
      checkOutput("edge_ch2_high", c2, 4);

      // Write landing on the wrap clock itself.
      writeDuty(0, 2);
      n = 0;
      while (mPhase != periodClocks() - 1 && n < 200) begin
         idle(1);
         n++;
      end
      writeDuty(0, 5);
      checkOutput("wrapwr_tick", int'(period_tick), 1);
      countHigh(DIV_PWM * STEPS, c0, c1, c2);
      checkOutput("wrapwr_first", c0, 8);
      countHigh(DIV_PWM * STEPS, c0, c1, c2);
      checkOutput("wrapwr_second", c0, 20);

      // Servo mode takes effect at the next boundary.
      curMode = 1'b1;
      writeDuty(0, 15);
      writeDuty(1, 0);
      writeDuty(2, 8);
      checkOutput("servo_mode_pre", int'(mode_act), 0);
      waitWrap(200);
      checkOutput("servo_mode_act", int'(mode_act), 1);
      countHigh(DIV_SERVO * STEPS, c0, c1, c2);
      checkOutput("servo_ch0_high", c0, 42);
      checkOutput("servo_ch1_high", c1, 18);
      checkOutput("servo_ch2_high", c2, 30);
      curMode = 1'b0;
      waitWrap(200);
      checkOutput("plain_mode_act", int'(mode_act), 0);

      // ena low for 10 clocks stretches the period by 10 and silences the outputs.
      writeDuty(0, 15);
      waitWrap(200);
      idle(20);
      for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      checkOutput("gate_pwm", int'(pwm_out), 0);
      n = 30;
      while (!period_tick && n < 200) begin
         idle(1);
         n++;
      end
      checkOutput("gate_period", n, DIV_PWM * STEPS + 10);

      // Reset mid-period clears shadows, so the following periods stay low.
      writeDuty(1, 12);
      idle(30);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
      checkOutput("midreset_pwm", int'(pwm_out), 0);
      waitWrap(200);
      countHigh(DIV_PWM * STEPS, c0, c1, c2);
      checkOutput("midreset_high", c0 + c1 + c2, 0);

      // Random traffic against the model.
      for (int k = 0; k < 4000; k++) begin
         r  = ($urandom_range(0, 799) == 0);
         e  = ($urandom_range(0, 15) != 0);
         we = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 199) == 0) curMode = ~curMode;
         applyStimulus(r, e, curMode, we, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
